// File: rtl/wisc_pkg.sv
// Shared constants and types for the WISC register file slice.
//   NREG     : number of architectural registers (power of two)
//   IDW      : register-id width, log2(NREG)
//   DW       : data width
//   ZERO_REG : id of the hard-wired zero register
package wisc_pkg;

   localparam int NREG     = 16;
   localparam int IDW      = 4;
   localparam int DW       = 16;
   localparam int ZERO_REG = 0;

   typedef logic [IDW-1:0]  reg_id_t;
   typedef logic [DW-1:0]   word_t;
   typedef logic [NREG-1:0] wordline_t;

endpackage

// File: rtl/onehot_to_idx.sv
// One-hot wordline encoder.
// Ports:
//   wordline : in  NREG-bit write wordline
//   valid    : out exactly one bit set and it is not the zero register
//   idx      : out index of the set bit (meaningful only when valid)
//   multi    : out more than one wordline bit set
module onehot_to_idx
   import wisc_pkg::*;
(
   input  logic [NREG-1:0] wordline,
   output logic            valid,
   output logic [IDW-1:0]  idx,
   output logic            multi
);

   logic seen_any;

   always_comb begin
      idx      = '0;
      seen_any = 1'b0;
      multi    = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         if (wordline[i]) begin
            if (seen_any) begin
               multi = 1'b1;
            end
            seen_any = 1'b1;
            // OR-encoding is exact for one-hot input; idx is ignored otherwise
            idx = idx | reg_id_t'(i);
         end
      end
      // A lone hit on register 0 is not a real write
      valid = seen_any & ~multi & (idx != reg_id_t'(ZERO_REG));
   end

endmodule

// File: rtl/regfile_read_port_sb.sv
// 16x16 register file with two registered read ports, same-cycle write
// bypass and a per-register busy scoreboard driving the decode stall.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   wordline, wr_data   : one-hot write wordline and write data
//   rd_en               : latch new read results this cycle
//   src_a_id, src_b_id  : read port register ids
//   rd_a_data, rd_b_data: registered read data
//   issue_en, dst_id    : issuing instruction claims dst_id
//   stall               : combinational, a source read this cycle is pending
//   busy_vec            : registered scoreboard bits
//   wl_err              : sticky multi-hot wordline flag
module regfile_read_port_sb
   import wisc_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREG-1:0] wordline,
   input  logic [DW-1:0]   wr_data,
   input  logic            rd_en,
   input  logic [IDW-1:0]  src_a_id,
   input  logic [IDW-1:0]  src_b_id,
   output logic [DW-1:0]   rd_a_data,
   output logic [DW-1:0]   rd_b_data,
   input  logic            issue_en,
   input  logic [IDW-1:0]  dst_id,
   output logic            stall,
   output logic [NREG-1:0] busy_vec,
   output logic            wl_err
);

   word_t     regs_reg [NREG];
   word_t     rd_a_reg, rd_b_reg;
   wordline_t busy_reg, busy_next;
   logic      wl_err_reg;

   logic      wl_valid, wl_multi;
   reg_id_t   wl_idx;

   logic      wb_hit_a, wb_hit_b;
   word_t     rd_a_next, rd_b_next;

   onehot_to_idx u_enc (
      .wordline (wordline),
      .valid    (wl_valid),
      .idx      (wl_idx),
      .multi    (wl_multi)
   );

   // wl_valid already excludes register 0, so id 0 never hits the bypass
   assign wb_hit_a = wl_valid & (wl_idx == src_a_id);
   assign wb_hit_b = wl_valid & (wl_idx == src_b_id);

   // regs_reg[0] is reset to zero and never written, so it reads as zero
   assign rd_a_next = wb_hit_a ? wr_data : regs_reg[src_a_id];
   assign rd_b_next = wb_hit_b ? wr_data : regs_reg[src_b_id];

   // busy_reg[0] is never set, so id 0 cannot stall
   assign stall = rd_en & ((busy_reg[src_a_id] & ~wb_hit_a) |
                           (busy_reg[src_b_id] & ~wb_hit_b));

   // Scoreboard next state: a new issue wins over a retiring writeback
   assign busy_next[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
         assign busy_next[gi] =
            (issue_en & (dst_id == reg_id_t'(gi))) |
            (busy_reg[gi] & ~(wl_valid & (wl_idx == reg_id_t'(gi))));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_reg[i] <= '0;
         end
         rd_a_reg   <= '0;
         rd_b_reg   <= '0;
         busy_reg   <= '0;
         wl_err_reg <= 1'b0;
      end else begin
         if (wl_valid) begin
            regs_reg[wl_idx] <= wr_data;
         end
         if (rd_en && !stall) begin
            rd_a_reg <= rd_a_next;
            rd_b_reg <= rd_b_next;
         end
         busy_reg <= busy_next;
         if (wl_multi) begin
            wl_err_reg <= 1'b1;
         end
      end
   end

   assign rd_a_data = rd_a_reg;
   assign rd_b_data = rd_b_reg;
   assign busy_vec  = busy_reg;
   assign wl_err    = wl_err_reg;

endmodule

// File: tb/tb_regfile_read_port_sb.sv
// Directed bench for regfile_read_port_sb. Inputs change 1 ns after the
// rising edge; registered outputs are sampled there, combinational stall
// is sampled after inputs settle.
module tb_regfile_read_port_sb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] wordline = '0;
   logic [15:0] wr_data = '0;
   logic        rd_en = 1'b0;
   logic [3:0]  src_a_id = '0;
   logic [3:0]  src_b_id = '0;
   logic [15:0] rd_a_data, rd_b_data;
   logic        issue_en = 1'b0;
   logic [3:0]  dst_id = '0;
   logic        stall;
   logic [15:0] busy_vec;
   logic        wl_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   regfile_read_port_sb dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wordline  (wordline),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .src_a_id  (src_a_id),
      .src_b_id  (src_b_id),
      .rd_a_data (rd_a_data),
      .rd_b_data (rd_b_data),
      .issue_en  (issue_en),
      .dst_id    (dst_id),
      .stall     (stall),
      .busy_vec  (busy_vec),
      .wl_err    (wl_err)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wordline = '0;
      rd_en    = 1'b0;
      issue_en = 1'b0;
   endtask

   initial begin
      // reset
      #2 rst_n = 1'b0;
      #1;
      chk("rst_rd_a", rd_a_data, 16'h0000);
      chk("rst_rd_b", rd_b_data, 16'h0000);
      chk("rst_busy", busy_vec, 16'h0000);
      chk("rst_wlerr", {15'd0, wl_err}, 16'h0000);
      tick();
      #2 rst_n = 1'b1;
      tick();

      // 1: write reg3 then read it
      wordline = 16'h0008; wr_data = 16'hBEEF;
      tick();
      idle(); rd_en = 1'b1; src_a_id = 4'd3;
      tick();
      chk("t1_rd_a", rd_a_data, 16'hBEEF);
      idle();

      // 2: register 0 protection
      wordline = 16'h0001; wr_data = 16'h1234;
      tick();
      idle(); rd_en = 1'b1; src_b_id = 4'd0;
      tick();
      chk("t2_rd_b_r0", rd_b_data, 16'h0000);
      idle(); issue_en = 1'b1; dst_id = 4'd0;
      tick();
      chk("t2_busy_r0", busy_vec, 16'h0000);
      idle();

      // 3: bypass on port A, port B reads reg3
      rd_en = 1'b1; src_a_id = 4'd5; src_b_id = 4'd3;
      wordline = 16'h0020; wr_data = 16'hA5A5;
      #1;
      chk("t3_stall", {15'd0, stall}, 16'h0000);
      tick();
      chk("t3_rd_a_byp", rd_a_data, 16'hA5A5);
      chk("t3_rd_b", rd_b_data, 16'hBEEF);
      idle();
      rd_en = 1'b1; src_a_id = 4'd5; src_b_id = 4'd0;
      tick();
      chk("t3_reg5_stored", rd_a_data, 16'hA5A5);
      idle();
      rd_en = 1'b1; src_a_id = 4'd0; src_b_id = 4'd3;
      tick();
      chk("t3_rd_a_r0", rd_a_data, 16'h0000);
      idle();

      // 4: scoreboard stall on port B
      issue_en = 1'b1; dst_id = 4'd7;
      tick();
      idle();
      chk("t4_busy_set", busy_vec, 16'h0080);
      rd_en = 1'b1; src_a_id = 4'd5; src_b_id = 4'd7;
      #1;
      chk("t4_stall", {15'd0, stall}, 16'h0001);
      tick();
      chk("t4_rd_b_held", rd_b_data, 16'hBEEF);
      chk("t4_rd_a_held", rd_a_data, 16'h0000);
      wordline = 16'h0080; wr_data = 16'h7777;
      #1;
      chk("t4_stall_wb", {15'd0, stall}, 16'h0000);
      tick();
      chk("t4_busy_clr", busy_vec, 16'h0000);
      chk("t4_rd_b_byp", rd_b_data, 16'h7777);
      chk("t4_rd_a_upd", rd_a_data, 16'hA5A5);
      idle();

      // 5: set/clear collision on reg4
      issue_en = 1'b1; dst_id = 4'd4;
      tick();
      chk("t5_busy_set", busy_vec, 16'h0010);
      issue_en = 1'b1; dst_id = 4'd4;
      wordline = 16'h0010; wr_data = 16'h4444;
      rd_en = 1'b1; src_a_id = 4'd4; src_b_id = 4'd0;
      tick();
      chk("t5_busy_keep", busy_vec, 16'h0010);
      chk("t5_rd_a_byp", rd_a_data, 16'h4444);
      idle();
      rd_en = 1'b1; src_a_id = 4'd0; src_b_id = 4'd4;
      #1;
      chk("t5_stall_r4", {15'd0, stall}, 16'h0001);
      idle();
      wordline = 16'h0010; wr_data = 16'h4444;
      tick();
      chk("t5_busy_retire", busy_vec, 16'h0000);
      idle();

      // 6: multi-hot wordline, then asynchronous reset
      wordline = 16'h0002; wr_data = 16'h1111;
      tick();
      wordline = 16'h0004; wr_data = 16'h2222;
      tick();
      idle();
      chk("t6_wlerr_clean", {15'd0, wl_err}, 16'h0000);
      wordline = 16'h0006; wr_data = 16'hDEAD;
      tick();
      chk("t6_wlerr_set", {15'd0, wl_err}, 16'h0001);
      idle(); rd_en = 1'b1; src_a_id = 4'd1; src_b_id = 4'd2;
      tick();
      chk("t6_reg1", rd_a_data, 16'h1111);
      chk("t6_reg2", rd_b_data, 16'h2222);
      chk("t6_wlerr_sticky", {15'd0, wl_err}, 16'h0001);
      idle(); issue_en = 1'b1; dst_id = 4'd9;
      tick();
      idle();
      chk("t6_busy9", busy_vec, 16'h0200);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_rd_a", rd_a_data, 16'h0000);
      chk("t6_rst_rd_b", rd_b_data, 16'h0000);
      chk("t6_rst_busy", busy_vec, 16'h0000);
      chk("t6_rst_wlerr", {15'd0, wl_err}, 16'h0000);
      #3 rst_n = 1'b1;
      tick();
      chk("t6_post_rst_rd_a", rd_a_data, 16'h0000);
      rd_en = 1'b1; src_a_id = 4'd1; src_b_id = 4'd2;
      tick();
      chk("t6_post_rst_reg1", rd_a_data, 16'h0000);
      chk("t6_post_rst_reg2", rd_b_data, 16'h0000);
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_read_port_sb.md
Name: regfile_read_port_sb

Overview:
- Read-side counterpart of the register file's one-hot write-wordline path.
- Holds the 16x16-bit architectural registers. Writes arrive as a 16-bit one-hot wordline plus data.
- Serves two registered read ports (A, B), with same-cycle write-to-read bypass.
- Keeps a per-register busy scoreboard that generates the decode-stage stall for the WISC pipeline.

Parameters:
- NREG, 16, number of registers; must be a power of two.
- IDW, 4, register-id width; equals log2(NREG).
- DW, 16, data width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wordline  in  NREG  one-hot write enable per register; all-zero means no write.
- wr_data  in  DW  write data for the selected register.
- rd_en  in  1  latch new read results this cycle.
- src_a_id  in  IDW  port A register id.
- src_b_id  in  IDW  port B register id.
- rd_a_data  out  DW  registered port A data.
- rd_b_data  out  DW  registered port B data.
- issue_en  in  1  an instruction claiming dst_id is issuing.
- dst_id  in  IDW  destination register of the issuing instruction.
- stall  out  1  combinational: a source read this cycle is still pending.
- busy_vec  out  NREG  registered scoreboard bits.
- wl_err  out  1  sticky flag: wordline had more than one bit set.

Behaviour:
- Reset (asynchronous on rst_n low):
  - all registers, rd_a_data, rd_b_data, busy_vec and wl_err go to 0.
  - Deassertion is used synchronously by downstream logic.
- Register 0 is hard-wired to zero:
  - wordline[0] is ignored.
  - reads of id 0 return 0.
  - busy_vec[0] is always 0.
- Write: on posedge, if wordline[i] is set (i ≠ 0), reg[i] <= wr_data.
- Multiple-hot wordline:
  - the write is suppressed entirely and wl_err <= 1.
  - wl_err clears only on reset.
- Read timing: 1-cycle latency. If rd_en is high at edge N, rd_x_data holds the value from edge N onward. If rd_en is low, the read outputs hold their previous values.
- Bypass: if wordline selects src_x_id in the same cycle as the rd_en read (valid one-hot, id ≠ 0), rd_x_data <= wr_data rather than the stale reg value.
- Scoreboard:
  - Set: issue_en with dst_id ≠ 0 sets busy[dst_id] at the edge.
  - Clear: a valid one-hot wordline[i] clears busy[i] at the edge.
  - Set and clear on the same register in the same cycle: set wins. The new producer is outstanding; the old writeback retires.
  - issue_en to an already-busy register keeps it busy. There is no counting: one outstanding producer per register is the pipeline contract.
- stall = rd_en & ((busy[src_a_id] & ~wb_hit_a) | (busy[src_b_id] & ~wb_hit_b)).
  - wb_hit_x = the current valid wordline writes src_x_id.
  - Ids of 0 never stall.
  - While stall is high, rd_a_data and rd_b_data are NOT updated, even though rd_en is high.
  - Issue gating is the caller's responsibility: issue_en is asserted only when stall is 0.
- Reset mid-operation: all pending busy bits are dropped and a read in flight is lost. Outputs read 0 until the first rd_en after reset.
- Widths: ids index directly into the NREG array with no wrap, since NREG = 2^IDW.

Decomposition:
- Shared package (wisc_pkg):
  - constants NREG, IDW, DW and ZERO_REG = 0.
  - typedef reg_id_t (IDW bits), word_t (DW bits), wordline_t (NREG bits).
- One natural sub-module: onehot_to_idx. It encodes wordline into {valid, idx} plus a multi-hot flag, and is shared by the bypass compare and scoreboard-clear logic.
- Storage, read muxes, bypass and scoreboard stay inline.

Test Plan:
1. Write then read: wordline=0x0008 with wr_data=0xBEEF; next cycle rd_en, src_a_id=3 -> rd_a_data=0xBEEF one cycle later.
2. R0 protection: wordline=0x0001 with wr_data=0x1234; then read src_b_id=0 -> rd_b_data=0x0000. Also issue_en with dst_id=0 -> busy_vec=0x0000.
3. Bypass: rd_en, src_a_id=5, and wordline=0x0020 with wr_data=0xA5A5 in the same cycle -> rd_a_data=0xA5A5 after one edge, and stall=0.
4. Scoreboard stall: issue_en dst_id=7 -> busy_vec=0x0080.
   - rd_en src_b_id=7 with no wordline -> stall=1 and rd_b_data unchanged.
   - Next cycle wordline=0x0080 -> stall=0, and busy_vec=0x0000 after the edge.
5. Set/clear collision: busy[4]=1; in the same cycle issue_en dst_id=4 and wordline=0x0010 -> reg4 updated and busy_vec[4] remains 1.
6. Error and reset: wordline=0x0006 -> reg1 and reg2 unchanged and wl_err=1 sticky. Then assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately, and wl_err=0.
